// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, synchronous flush,
// optional two-entry skid buffer and saturating stall/flush counters.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_EMPTY | no entry held; outputs present a NOP bubble
// ST_HALF  | one entry in MAIN, presented downstream
// ST_FULL  | MAIN presented, SKID holds the next entry (SKID=1 only)
module pipe_stage_skid #(
   parameter int CTRL_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter int SKID       = 1,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [CTRL_WIDTH-1:0] ctrl_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  flush_i,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [CTRL_WIDTH-1:0] ctrl_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic [1:0]            occ_o,
   output logic [CNT_WIDTH-1:0]  stall_cnt_o,
   output logic [CNT_WIDTH-1:0]  flush_cnt_o
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_HALF  = 2'b01,
      ST_FULL  = 2'b10
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t                  state_q, state_d;
   logic [CTRL_WIDTH-1:0]   main_ctrl_q, main_ctrl_d;
   logic [DATA_WIDTH-1:0]   main_data_q, main_data_d;
   logic [CTRL_WIDTH-1:0]   skid_ctrl_q, skid_ctrl_d;
   logic [DATA_WIDTH-1:0]   skid_data_q, skid_data_d;
   logic [CNT_WIDTH-1:0]    stall_cnt_q, stall_cnt_d;
   logic [CNT_WIDTH-1:0]    flush_cnt_q, flush_cnt_d;
   logic                    push;
   logic                    pop;

   // With the skid entry, ready is a pure function of state so it can be
   // timed as a register output; without it, ready must look through ready_i.
   assign valid_o = (state_q != ST_EMPTY);
   assign ready_o = (SKID != 0) ? (state_q != ST_FULL) : (!valid_o || ready_i);
   assign push    = valid_i && ready_o;
   assign pop     = valid_o && ready_i;

   // Gate the head entry so a bubble can never carry a write enable.
   assign ctrl_o      = valid_o ? main_ctrl_q : '0;
   assign data_o      = valid_o ? main_data_q : '0;
   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;

   // Occupancy decoded from state.
   always_comb begin
      occ_o = 2'd0;
      case (state_q)
         ST_HALF: occ_o = 2'd1;
         ST_FULL: occ_o = 2'd2;
         default: occ_o = 2'd0;
      endcase
   end

   // Next state and entry registers; flush overrides every transition.
   always_comb begin
      state_d     = state_q;
      main_ctrl_d = main_ctrl_q;
      main_data_d = main_data_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_data_d = skid_data_q;
      if (flush_i) begin
         state_d     = ST_EMPTY;
         main_ctrl_d = '0;
         main_data_d = '0;
         skid_ctrl_d = '0;
         skid_data_d = '0;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (push) begin
                  state_d     = ST_HALF;
                  main_ctrl_d = ctrl_i;
                  main_data_d = data_i;
               end
            end
            ST_HALF: begin
               if (push && !pop && (SKID != 0)) begin
                  state_d     = ST_FULL;
                  skid_ctrl_d = ctrl_i;
                  skid_data_d = data_i;
               end else if (!push && pop) begin
                  state_d     = ST_EMPTY;
                  main_ctrl_d = '0;
                  main_data_d = '0;
               end else if (push && pop) begin
                  main_ctrl_d = ctrl_i;
                  main_data_d = data_i;
               end
            end
            ST_FULL: begin
               if (pop) begin
                  state_d     = ST_HALF;
                  main_ctrl_d = skid_ctrl_q;
                  main_data_d = skid_data_q;
                  skid_ctrl_d = '0;
                  skid_data_d = '0;
               end
            end
            default: begin
               state_d     = ST_EMPTY;
               main_ctrl_d = '0;
               main_data_d = '0;
               skid_ctrl_d = '0;
               skid_data_d = '0;
            end
         endcase
      end
   end

   // Saturating performance counters; flush leaves them untouched.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (valid_o && !ready_i && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
      if (flush_i && (state_q != ST_EMPTY) && (flush_cnt_q != CNT_MAX)) begin
         flush_cnt_d = flush_cnt_q + CNT_ONE;
      end
   end

   // State, entry and counter registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_EMPTY;
         main_ctrl_q <= '0;
         main_data_q <= '0;
         skid_ctrl_q <= '0;
         skid_data_q <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         main_ctrl_q <= main_ctrl_d;
         main_data_q <= main_data_d;
         skid_ctrl_q <= skid_ctrl_d;
         skid_data_q <= skid_data_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

endmodule
